// File: rtl/lsu_dc_arb_if.sv
// LSU-lane / D-cache request and response bundle for lsu_dc_arb.
// Lane-indexed fields are packed [1:0] arrays; index 0 is lane0.
interface lsu_dc_arb_if #(
  parameter int TAG_W = 8
);
  logic [1:0]             req_valid_i;
  logic [1:0]             req_ready_o;
  logic [1:0][63:0]       req_addr_i;
  logic [1:0][63:0]       req_wdata_i;
  logic [1:0][7:0]        req_wstrb_i;
  logic [1:0]             req_is_write_i;
  logic [1:0][TAG_W-1:0]  req_rob_idx_i;

  logic                   dc_req_valid_o;
  logic                   dc_req_ready_i;
  logic [63:0]            dc_req_addr_o;
  logic [63:0]            dc_req_wdata_o;
  logic [7:0]             dc_req_wstrb_o;
  logic                   dc_req_is_write_o;

  logic                   dc_rsp_valid_i;
  logic [63:0]            dc_rsp_rdata_i;

  logic [1:0]             rsp_valid_o;
  logic [1:0][63:0]       rsp_rdata_o;
  logic [1:0][TAG_W-1:0]  rsp_rob_idx_o;
  logic [1:0]             rsp_is_write_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, req_is_write_i, req_rob_idx_i,
    output req_ready_o,
    output dc_req_valid_o, dc_req_addr_o, dc_req_wdata_o, dc_req_wstrb_o, dc_req_is_write_o,
    input  dc_req_ready_i, dc_rsp_valid_i, dc_rsp_rdata_i,
    output rsp_valid_o, rsp_rdata_o, rsp_rob_idx_o, rsp_is_write_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, req_is_write_i, req_rob_idx_i,
    input  req_ready_o,
    input  dc_req_valid_o, dc_req_addr_o, dc_req_wdata_o, dc_req_wstrb_o, dc_req_is_write_o,
    output dc_req_ready_i, dc_rsp_valid_i, dc_rsp_rdata_i,
    input  rsp_valid_o, rsp_rdata_o, rsp_rob_idx_o, rsp_is_write_o
  );
endinterface

// File: rtl/lsu_dc_arb.sv
// Two-lane LSU to single L1 D-cache request arbiter with an ordered tag FIFO
// that steers in-order cache responses back to the issuing lane and ROB index.
module lsu_dc_arb #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_dc_arb_if.slave           bus,
  output logic [$clog2(DEPTH):0] outstanding_o,
  output logic                  err_spurious_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                  rr_q, rr_d;
  logic                  lock_q, lock_d;
  logic                  lock_lane_q, lock_lane_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q;

  logic [DEPTH-1:0]      lane_mem;
  logic [DEPTH-1:0]      wr_mem;
  logic [TAG_W-1:0]      rob_mem [DEPTH];

  logic [1:0]            rsp_vld_q;
  logic [1:0][63:0]      rsp_rdata_q;
  logic [1:0][TAG_W-1:0] rsp_rob_q;
  logic [1:0]            rsp_wr_q;

  logic full, gnt_vld, gnt, dc_vld, accept, stall, pop, spurious, head_lane;

  // A stalled lane keeps the grant for as long as it holds valid.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (lock_q && bus.req_valid_i[lock_lane_q]) begin
      gnt_vld = 1'b1;
      gnt     = lock_lane_q;
    end else if (&bus.req_valid_i) begin
      gnt_vld = 1'b1;
      gnt     = rr_q;
    end else if (bus.req_valid_i[0]) begin
      gnt_vld = 1'b1;
      gnt     = 1'b0;
    end else if (bus.req_valid_i[1]) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
    end
  end

  assign full      = (cnt_q == CW'(DEPTH));
  assign dc_vld    = gnt_vld & ~full;
  assign accept    = dc_vld & bus.dc_req_ready_i;
  assign stall     = dc_vld & ~bus.dc_req_ready_i;
  assign pop       = bus.dc_rsp_valid_i & (cnt_q != '0);
  assign spurious  = bus.dc_rsp_valid_i & (cnt_q == '0);
  assign head_lane = lane_mem[rd_ptr_q];

  assign bus.dc_req_valid_o    = dc_vld;
  assign bus.req_ready_o       = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.dc_req_addr_o     = bus.req_addr_i[gnt];
  assign bus.dc_req_wdata_o    = bus.req_wdata_i[gnt];
  assign bus.dc_req_wstrb_o    = bus.req_wstrb_i[gnt];
  assign bus.dc_req_is_write_o = bus.req_is_write_i[gnt];

  always_comb begin
    rr_d        = rr_q;
    lock_d      = lock_q;
    lock_lane_d = lock_lane_q;
    if (accept) begin
      rr_d   = ~gnt;
      lock_d = 1'b0;
    end else if (stall) begin
      lock_d      = 1'b1;
      lock_lane_d = gnt;
    end else begin
      lock_d = lock_q & bus.req_valid_i[lock_lane_q];
    end
    cnt_d = cnt_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= 1'b0;
      lock_q      <= 1'b0;
      lock_lane_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_lane_q <= lock_lane_d;
      cnt_q       <= cnt_d;
      if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      if (spurious) err_q <= 1'b1;
    end
  end

  // Tag storage is qualified by the pointers and count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_mem[wr_ptr_q] <= gnt;
      wr_mem[wr_ptr_q]   <= bus.req_is_write_i[gnt];
      rob_mem[wr_ptr_q]  <= bus.req_rob_idx_i[gnt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_rob_q   <= '0;
      rsp_wr_q    <= '0;
    end else begin
      rsp_vld_q <= '0;
      if (pop) begin
        rsp_vld_q[head_lane]   <= 1'b1;
        rsp_rdata_q[head_lane] <= bus.dc_rsp_rdata_i;
        rsp_rob_q[head_lane]   <= rob_mem[rd_ptr_q];
        rsp_wr_q[head_lane]    <= wr_mem[rd_ptr_q];
      end
    end
  end

  assign bus.rsp_valid_o    = rsp_vld_q;
  assign bus.rsp_rdata_o    = rsp_rdata_q;
  assign bus.rsp_rob_idx_o  = rsp_rob_q;
  assign bus.rsp_is_write_o = rsp_wr_q;
  assign outstanding_o      = cnt_q;
  assign err_spurious_o     = err_q;
endmodule

// File: tb/tb_lsu_dc_arb.sv
// Bench for lsu_dc_arb: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based reference model.
module tb_lsu_dc_arb;
  localparam int DEPTH = 4;
  localparam int TAG_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic [$clog2(DEPTH):0] outstanding;
  logic err_spurious;

  lsu_dc_arb_if #(.TAG_W(TAG_W)) bus ();

  lsu_dc_arb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .outstanding_o  (outstanding),
    .err_spurious_o (err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         lane;
    logic [7:0] rob;
    bit         wr;
  } ent_t;

  ent_t        m_q[$];
  bit          m_rr, m_lock, m_lock_lane, m_err;
  logic [1:0]  e_vld;
  logic [63:0] e_rdata [2];
  logic [7:0]  e_rob [2];
  logic        e_wr [2];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr = 0; m_lock = 0; m_lock_lane = 0; m_err = 0;
    e_vld = '0;
    for (int l = 0; l < 2; l++) begin
      e_rdata[l] = '0; e_rob[l] = '0; e_wr[l] = 1'b0;
    end
  endtask

  // Arbitration rules: locked lane first, round-robin on a tie, else the lone requester.
  function automatic void grant(output bit has, output bit g);
    has = 1'b1; g = 1'b0;
    if (m_lock && bus.req_valid_i[m_lock_lane]) g = m_lock_lane;
    else if (bus.req_valid_i == 2'b11)          g = m_rr;
    else if (bus.req_valid_i[0])                g = 1'b0;
    else if (bus.req_valid_i[1])                g = 1'b1;
    else                                        has = 1'b0;
  endfunction

  task automatic check_all();
    bit has, g, dcv;
    grant(has, g);
    dcv = has && (m_q.size() < DEPTH);
    chk("dc_req_valid", 64'(bus.dc_req_valid_o), 64'(dcv));
    chk("req_ready", 64'(bus.req_ready_o),
        (dcv && bus.dc_req_ready_i) ? (g ? 64'd2 : 64'd1) : 64'd0);
    if (dcv) begin
      chk("dc_req_addr", bus.dc_req_addr_o, bus.req_addr_i[g]);
      chk("dc_req_wdata", bus.dc_req_wdata_o, bus.req_wdata_i[g]);
      chk("dc_req_wstrb", 64'(bus.dc_req_wstrb_o), 64'(bus.req_wstrb_i[g]));
      chk("dc_req_is_write", 64'(bus.dc_req_is_write_o), 64'(bus.req_is_write_i[g]));
    end
    chk("outstanding", 64'(outstanding), 64'(m_q.size()));
    chk("err_spurious", 64'(err_spurious), 64'(m_err));
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(e_vld));
    for (int l = 0; l < 2; l++) begin
      chk("rsp_rdata", bus.rsp_rdata_o[l], e_rdata[l]);
      chk("rsp_rob_idx", 64'(bus.rsp_rob_idx_o[l]), 64'(e_rob[l]));
      chk("rsp_is_write", 64'(bus.rsp_is_write_o[l]), 64'(e_wr[l]));
    end
  endtask

  task automatic model_update();
    bit has, g, dcv, acc;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    grant(has, g);
    dcv = has && (m_q.size() < DEPTH);
    acc = dcv && bus.dc_req_ready_i;
    e_vld = '0;
    if (bus.dc_rsp_valid_i) begin
      if (m_q.size() == 0) m_err = 1'b1;
      else begin
        e = m_q.pop_front();
        e_vld[e.lane]   = 1'b1;
        e_rdata[e.lane] = bus.dc_rsp_rdata_i;
        e_rob[e.lane]   = e.rob;
        e_wr[e.lane]    = e.wr;
      end
    end
    if (acc) begin
      e.lane = g; e.rob = bus.req_rob_idx_i[g]; e.wr = bus.req_is_write_i[g];
      m_q.push_back(e);
      m_rr = ~g;
      m_lock = 1'b0;
    end else if (dcv) begin
      m_lock = 1'b1;
      m_lock_lane = g;
    end else begin
      m_lock = m_lock && bus.req_valid_i[m_lock_lane];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_lane(input int l, input bit v, input logic [63:0] addr,
                          input logic [7:0] rob, input bit wr);
    bus.req_valid_i[l]    = v;
    bus.req_addr_i[l]     = addr;
    bus.req_wdata_i[l]    = {addr[31:0], ~addr[31:0]};
    bus.req_wstrb_i[l]    = wr ? 8'hFF : 8'h00;
    bus.req_is_write_i[l] = wr;
    bus.req_rob_idx_i[l]  = rob;
  endtask

  task automatic drain();
    bus.req_valid_i = 2'b00;
    for (int i = 0; i < DEPTH + 2 && m_q.size() > 0; i++) begin
      bus.dc_rsp_valid_i = 1'b1;
      bus.dc_rsp_rdata_i = {$urandom, $urandom};
      cycle();
    end
    bus.dc_rsp_valid_i = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i = '0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.req_wstrb_i = '0; bus.req_is_write_i = '0; bus.req_rob_idx_i = '0;
    bus.dc_req_ready_i = 1'b0; bus.dc_rsp_valid_i = 1'b0; bus.dc_rsp_rdata_i = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 rst = 1'b0;
    cycle();

    // Single load on lane0 and its response
    set_lane(0, 1'b1, 64'h1000, 8'd5, 1'b0);
    bus.dc_req_ready_i = 1'b1;
    #1;
    chk("t1_dc_valid", 64'(bus.dc_req_valid_o), 64'd1);
    chk("t1_ready", 64'(bus.req_ready_o), 64'd1);
    cycle();
    bus.req_valid_i = 2'b00;
    bus.dc_rsp_valid_i = 1'b1;
    bus.dc_rsp_rdata_i = 64'hDEAD;
    cycle();
    bus.dc_rsp_valid_i = 1'b0;
    chk("t1_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("t1_rsp_rdata", bus.rsp_rdata_o[0], 64'hDEAD);
    chk("t1_rsp_rob", 64'(bus.rsp_rob_idx_o[0]), 64'd5);
    cycle();

    // Both lanes always valid: alternating grants, responses one cycle behind
    for (int i = 0; i < 6; i++) begin
      set_lane(0, 1'b1, 64'h2000 + 64'(i * 8), 8'(16 + i), i[0]);
      set_lane(1, 1'b1, 64'h3000 + 64'(i * 8), 8'(32 + i), ~i[0]);
      bus.dc_rsp_valid_i = (m_q.size() > 0);
      bus.dc_rsp_rdata_i = 64'hA000 + 64'(i);
      cycle();
    end
    drain();

    // Lane1 stalled three cycles while lane0 also requests
    set_lane(0, 1'b1, 64'h4000, 8'd40, 1'b0);
    bus.dc_req_ready_i = 1'b1;
    cycle();
    set_lane(0, 1'b1, 64'h4100, 8'd41, 1'b0);
    set_lane(1, 1'b1, 64'h5100, 8'd51, 1'b1);
    bus.dc_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_locked_addr", bus.dc_req_addr_o, 64'h5100);
      cycle();
    end
    bus.dc_req_ready_i = 1'b1;
    #1 chk("t3_lane1_ready", 64'(bus.req_ready_o), 64'd2);
    cycle();
    #1 chk("t3_lane0_next", bus.dc_req_addr_o, 64'h4100);
    cycle();
    drain();

    // Fill to DEPTH; full blocks grants until a response frees a slot
    bus.dc_req_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_lane(0, 1'b1, 64'h6000 + 64'(i * 64), 8'(60 + i), 1'b0);
      cycle();
    end
    #1;
    chk("t4_outstanding_full", 64'(outstanding), 64'(DEPTH));
    chk("t4_no_grant_full", 64'(bus.dc_req_valid_o), 64'd0);
    bus.dc_rsp_valid_i = 1'b1;
    bus.dc_rsp_rdata_i = 64'h600D;
    #1 chk("t4_no_grant_on_pop", 64'(bus.dc_req_valid_o), 64'd0);
    cycle();
    bus.dc_rsp_valid_i = 1'b0;
    #1;
    chk("t4_outstanding_after_pop", 64'(outstanding), 64'(DEPTH - 1));
    chk("t4_grant_again", 64'(bus.dc_req_valid_o), 64'd1);
    cycle();
    drain();

    // Spurious response and reset clearing the sticky error
    bus.dc_rsp_valid_i = 1'b1;
    cycle();
    bus.dc_rsp_valid_i = 1'b0;
    chk("t5_err_set", 64'(err_spurious), 64'd1);
    chk("t5_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    cycle();
    chk("t5_err_sticky", 64'(err_spurious), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_err_cleared", 64'(err_spurious), 64'd0);
    chk("t5_outstanding_cleared", 64'(outstanding), 64'd0);

    // Reset with requests in flight restores lane0 priority on a tie
    bus.req_valid_i = 2'b00;
    set_lane(1, 1'b1, 64'h7100, 8'd71, 1'b0);
    cycle();
    bus.req_valid_i[1] = 1'b0;
    set_lane(0, 1'b1, 64'h7000, 8'd70, 1'b0);
    cycle();
    bus.req_valid_i = 2'b00;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_outstanding_reset", 64'(outstanding), 64'd0);
    set_lane(0, 1'b1, 64'h7200, 8'd72, 1'b0);
    set_lane(1, 1'b1, 64'h7300, 8'd73, 1'b0);
    #1 chk("t6_tie_lane0", 64'(bus.req_ready_o), 64'd1);
    cycle();
    drain();

    // Random traffic; a locked lane keeps its request stable or drops valid
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int l = 0; l < 2; l++) begin
        if (m_lock && m_lock_lane == l[0] && bus.req_valid_i[l]) begin
          if ($urandom_range(0, 9) == 0) bus.req_valid_i[l] = 1'b0;
        end else begin
          set_lane(l, ($urandom_range(0, 9) < 6), {$urandom, $urandom},
                   8'($urandom), 1'($urandom));
        end
      end
      bus.dc_req_ready_i = ($urandom_range(0, 9) < 7);
      bus.dc_rsp_valid_i = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.dc_rsp_rdata_i = {$urandom, $urandom};
      cycle();
    end
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_dc_arb.md
Name: lsu_dc_arb

Overview:
Arbitrates the two LSU memory-request lanes onto a single L1 D-cache request port. Responses return in order and are steered back to the lane and ROB index that issued them. Sits between the LSU (upstream) and the L1 D-cache (downstream). The number of in-flight requests is bounded by an internal ordered tag FIFO.

Parameters:
DEPTH, 4, maximum outstanding cache requests (tag FIFO entries); power of two, at least 2.
TAG_W, 8, width of the ROB index carried with each request.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
req_valid_i[2]  in  1  lane request valid.
req_ready_o[2]  out  1  lane request accepted this cycle (combinational).
req_addr_i[2]  in  64  byte address.
req_wdata_i[2]  in  64  store data.
req_wstrb_i[2]  in  8  store byte strobes.
req_is_write_i[2]  in  1  1 = store, 0 = load.
req_rob_idx_i[2]  in  TAG_W  ROB index of the request.
dc_req_valid_o  out  1  cache request valid.
dc_req_ready_i  in  1  cache accepts the request.
dc_req_addr_o / dc_req_wdata_o / dc_req_wstrb_o / dc_req_is_write_o  out  64/64/8/1  muxed from the granted lane.
dc_rsp_valid_i  in  1  cache response, in request order (loads and stores).
dc_rsp_rdata_i  in  64  load data; ignored for stores.
rsp_valid_o[2]  out  1  per-lane response valid (registered).
rsp_rdata_o[2]  out  64  response data.
rsp_rob_idx_o[2]  out  TAG_W  ROB index of the response.
rsp_is_write_o[2]  out  1  response is a store acknowledge.
outstanding_o  out  $clog2(DEPTH)+1  live count of in-flight requests.
err_spurious_o  out  1  sticky; set on a response received while the FIFO is empty.

Behaviour:
- Synchronous, active-high reset: single clock clk; reset rst, synchronous, active-high.
- Values during reset: rr_q=0, lock_q=0, count=0, FIFO pointers=0, rsp_valid_o=0, err_spurious_o=0. rsp_rdata_o, rsp_rob_idx_o and rsp_is_write_o are cleared to 0.
- full = (count == DEPTH). While full, no grant is issued: dc_req_valid_o=0 and both req_ready_o=0.
- Grant selection (combinational):
  - If lock_q=1 and req_valid_i[lock_lane_q]=1, grant lock_lane_q.
  - Else if both lanes are valid, grant lane rr_q.
  - Else grant whichever lane is valid. If neither is valid, no grant.
- dc_req_valid_o = granted & !full. The dc_req_* fields are the granted lane's inputs. dc_req_valid_o is not gated by dc_req_ready_i.
- req_ready_o[g] = dc_req_valid_o & dc_req_ready_i for the granted lane g. The other lane's req_ready_o is 0.
- Accept (dc_req_valid_o & dc_req_ready_i):
  - Push {lane, rob_idx, is_write} into the FIFO.
  - Set rr_q = !g.
  - Clear lock_q.
- Stall (dc_req_valid_o & !dc_req_ready_i): set lock_q=1 and lock_lane_q=g. The granted lane must hold its request stable.
  - If the locked lane drops valid, the lock is released that cycle and normal arbitration applies.
- Response (dc_rsp_valid_i with count>0): pop the FIFO head. Next cycle:
  - rsp_valid_o[head.lane]=1, with rsp_rdata_o, rsp_rob_idx_o and rsp_is_write_o for that lane loaded.
  - The other lane's rsp_valid_o=0.
  - Response latency is 1 cycle. rsp_valid_o is a single-cycle pulse.
- Response with count==0: no pop, no rsp_valid_o, err_spurious_o<=1 (held until reset).
- Simultaneous accept and response in one cycle: push and pop both happen, count is unchanged.
  - Grant eligibility uses the registered count. A full FIFO does not grant even if a pop occurs that cycle.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. count ranges 0..DEPTH. outstanding_o = count.
- Reset asserted mid-operation: all in-flight tags are discarded. Responses arriving after reset are treated as spurious.

Test Plan:
1. Single load on lane0, addr 0x1000, rob 5, dc_req_ready_i=1 → dc_req_valid_o=1, req_ready_o[0]=1 in the same cycle. Response rdata 0xDEAD → one cycle later rsp_valid_o[0]=1, rsp_rdata_o[0]=0xDEAD, rsp_rob_idx_o[0]=5.
2. Both lanes valid every cycle, cache always ready → grants alternate lane0, lane1, lane0, lane1. Responses return to the matching lanes in issue order.
3. Lane1 granted with dc_req_ready_i=0 for 3 cycles while lane0 is also valid → lane1 is held (lock) for all 3 cycles and accepted on the 4th. Lane0 is granted the next cycle.
4. Issue 4 requests with no responses, DEPTH=4 → outstanding_o=4, dc_req_valid_o=0 even with requests pending. One response → count=3, and the next cycle grants again.
5. dc_rsp_valid_i pulse with an empty FIFO → err_spurious_o=1 and stays 1, no rsp_valid_o. Assert rst → err_spurious_o=0, outstanding_o=0.
6. Two requests outstanding, rst asserted for 1 cycle → count=0, rr_q=0. A subsequent lane0/lane1 tie grants lane0 first.
